// File: rtl/qam_mapper.sv
// qam_mapper: gathers 1/2/4/6 coded bits per point and maps BPSK/QPSK/16QAM/64QAM to {Im,Re}.
// Latency 1 cycle accept-to-STB_O; STB_O/DAT_O hold until ACK_I and ACK_O is withheld meanwhile.
module qam_mapper #(
    parameter int DW = 16
) (
    input  logic            CLK_I,
    input  logic            RST_I,
    input  logic [1:0]      MODE_I,
    input  logic [1:0]      DAT_I,
    input  logic            CYC_I,
    input  logic            STB_I,
    input  logic            WE_I,
    output logic            ACK_O,
    output logic [2*DW-1:0] DAT_O,
    output logic            CYC_O,
    output logic            STB_O,
    output logic            WE_O,
    input  logic            ACK_I
);

    localparam int SH = DW - 16;

    // Q2.14 magnitudes at DW=16, scaled up for wider components
    localparam logic [DW-1:0] L_BPSK = DW'(16384) << SH;
    localparam logic [DW-1:0] L_QPSK = DW'(11585) << SH;
    localparam logic [DW-1:0] L16_1  = DW'(5181)  << SH;
    localparam logic [DW-1:0] L16_3  = DW'(15543) << SH;
    localparam logic [DW-1:0] L64_1  = DW'(2528)  << SH;
    localparam logic [DW-1:0] L64_3  = DW'(7584)  << SH;
    localparam logic [DW-1:0] L64_5  = DW'(12641) << SH;
    localparam logic [DW-1:0] L64_7  = DW'(17697) << SH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [3:0]      bits_q, bits_d;
    logic [2*DW-1:0] dat_q, dat_d;
    logic            stb_q, stb_d;
    logic            cyc_q, cyc_d;

    logic            out_halt;
    logic            ena;
    logic            flush_fire;
    logic            frame_start;
    logic            frame_end;
    logic [1:0]      last_cnt;
    logic            last_beat;
    logic [5:0]      sym_bits;

    function automatic logic [DW-1:0] signed_lvl(input logic pos, input logic [DW-1:0] mag);
        return pos ? mag : -mag;
    endfunction

    function automatic logic [DW-1:0] mag16(input logic inner);
        return inner ? L16_1 : L16_3;
    endfunction

    function automatic logic [DW-1:0] mag64(input logic [1:0] inner);
        logic [DW-1:0] m;
        case (inner)
            2'b00:   m = L64_7;
            2'b01:   m = L64_5;
            2'b11:   m = L64_3;
            default: m = L64_1;
        endcase
        return m;
    endfunction

    // b[0] is the earliest bit; a 0 bit in the sign position selects the negative side
    function automatic logic [2*DW-1:0] map_sym(input logic [1:0] mode, input logic [5:0] b);
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        re = '0;
        im = '0;
        case (mode)
            2'd0: re = signed_lvl(b[0], L_BPSK);
            2'd1: begin
                re = signed_lvl(b[0], L_QPSK);
                im = signed_lvl(b[1], L_QPSK);
            end
            2'd2: begin
                re = signed_lvl(b[0], mag16(b[1]));
                im = signed_lvl(b[2], mag16(b[3]));
            end
            default: begin
                re = signed_lvl(b[0], mag64({b[1], b[2]}));
                im = signed_lvl(b[3], mag64({b[4], b[5]}));
            end
        endcase
        return {im, re};
    endfunction

    assign out_halt = stb_q & ~ACK_I;
    assign ena      = CYC_I & STB_I & WE_I;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (CYC_I) state_d = S_RUN;
            S_RUN:   if (!CYC_I) state_d = (cnt_q != 2'd0) ? S_FLUSH : S_DRAIN;
            S_FLUSH: if (!out_halt) state_d = S_DRAIN;
            S_DRAIN: if (!stb_q || ACK_I) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ACK_O       = 1'b0;
        flush_fire  = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            S_IDLE:  frame_start = CYC_I;
            S_RUN:   ACK_O       = ena & ~out_halt;
            S_FLUSH: flush_fire  = ~out_halt;
            S_DRAIN: frame_end   = ~stb_q | ACK_I;
            default: ;
        endcase
    end

    always_comb begin
        case (mode_q)
            2'd3:    last_cnt = 2'd2;
            2'd2:    last_cnt = 2'd1;
            default: last_cnt = 2'd0;
        endcase
        last_beat = (cnt_q == last_cnt);

        case (cnt_q)
            2'd0:    sym_bits = {4'b0000, DAT_I};
            2'd1:    sym_bits = {2'b00, DAT_I, bits_q[1:0]};
            default: sym_bits = {DAT_I, bits_q};
        endcase
    end

    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        bits_d = bits_q;
        dat_d  = dat_q;
        stb_d  = stb_q;
        cyc_d  = cyc_q;

        if (stb_q && ACK_I) begin
            stb_d = 1'b0;
        end

        if (ACK_O) begin
            if (last_beat) begin
                cnt_d  = 2'd0;
                bits_d = 4'b0000;
                dat_d  = map_sym(mode_q, sym_bits);
                stb_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    bits_d[1:0] = DAT_I;
                end else begin
                    bits_d[3:2] = DAT_I;
                end
            end
        end

        // bits_q is kept zero above the gathered bits, so padding is free
        if (flush_fire) begin
            cnt_d  = 2'd0;
            bits_d = 4'b0000;
            dat_d  = map_sym(mode_q, {2'b00, bits_q});
            stb_d  = 1'b1;
        end

        if (frame_start) begin
            mode_d = MODE_I;
            cyc_d  = 1'b1;
            cnt_d  = 2'd0;
            bits_d = 4'b0000;
        end

        if (frame_end) begin
            cyc_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            mode_q <= 2'd0;
            cnt_q  <= 2'd0;
            bits_q <= 4'b0000;
            dat_q  <= '0;
            stb_q  <= 1'b0;
            cyc_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            bits_q <= bits_d;
            dat_q  <= dat_d;
            stb_q  <= stb_d;
            cyc_q  <= cyc_d;
        end
    end

    assign DAT_O = dat_q;
    assign STB_O = stb_q;
    assign WE_O  = stb_q;
    assign CYC_O = cyc_q;

endmodule

// File: tb/tb_qam_mapper.sv
// Randomised bench for qam_mapper: DW=16 and DW=20 instances share stimulus and are
// scored against a bit-list / gray-decode reference model of the constellations.
module tb_qam_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  mode_i;
    logic [1:0]  dat_i;
    logic        cyc_i, stb_i, we_i, ack_i;
    logic        ack_o, cyc_o, stb_o, we_o;
    logic [31:0] dat_o;
    logic        ack_o20, cyc_o20, stb_o20, we_o20;
    logic [39:0] dat_o20;

    qam_mapper #(.DW(16)) u_dut (
        .CLK_I(clk), .RST_I(rst), .MODE_I(mode_i), .DAT_I(dat_i),
        .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ACK_O(ack_o),
        .DAT_O(dat_o), .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o), .ACK_I(ack_i)
    );

    qam_mapper #(.DW(20)) u_dut20 (
        .CLK_I(clk), .RST_I(rst), .MODE_I(mode_i), .DAT_I(dat_i),
        .CYC_I(cyc_i), .STB_I(stb_i), .WE_I(we_i), .ACK_O(ack_o20),
        .DAT_O(dat_o20), .CYC_O(cyc_o20), .STB_O(stb_o20), .WE_O(we_o20), .ACK_I(ack_i)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    int          fmode = 0;
    int          mb[6];
    int          mn = 0;
    logic [31:0] exp16_q[$];
    logic [39:0] exp20_q[$];
    logic [31:0] const16_q[$];
    logic [39:0] const20_q[$];
    int          sym_cnt = 0;
    int          run = 0;
    int          run_max = 0;
    int          ack_mode = 0;

    function automatic int lvl(input int md, input int v);
        int g, amp, mag, k;
        if (md == 0) return (v != 0) ? 16384 : -16384;
        if (md == 1) return (v != 0) ? 11585 : -11585;
        g   = v ^ (v >> 1) ^ (v >> 2);
        amp = 2 * g - ((md == 2) ? 3 : 7);
        k   = ((amp < 0 ? -amp : amp) - 1) / 2;
        if (md == 2) begin
            mag = (k == 0) ? 5181 : 15543;
        end else begin
            case (k)
                0:       mag = 2528;
                1:       mag = 7584;
                2:       mag = 12641;
                default: mag = 17697;
            endcase
        end
        return (amp < 0) ? -mag : mag;
    endfunction

    function automatic int nbits(input int md);
        case (md)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int bits_val(input int first, input int n);
        int v;
        v = 0;
        for (int i = 0; i < n; i++) v = (v << 1) | mb[first + i];
        return v;
    endfunction

    function automatic logic [31:0] pk16(input int im, input int re);
        return {16'(im), 16'(re)};
    endfunction

    task automatic clear_bits();
        for (int i = 0; i < 6; i++) mb[i] = 0;
        mn = 0;
    endtask

    task automatic push_sym();
        int per, re, im;
        if (fmode == 0) begin
            re = lvl(0, mb[0]);
            im = 0;
        end else begin
            per = nbits(fmode) / 2;
            re  = lvl(fmode, bits_val(0, per));
            im  = lvl(fmode, bits_val(per, per));
        end
        exp16_q.push_back(pk16(im, re));
        exp20_q.push_back({20'(im * 16), 20'(re * 16)});
        clear_bits();
    endtask

    // monitor: samples on the falling edge, mid-way between active edges
    logic [31:0] e16;
    logic [39:0] e20;
    initial begin
        clear_bits();
        forever begin
            @(negedge clk);
            if (rst) begin
                exp16_q.delete();
                exp20_q.delete();
                const16_q.delete();
                const20_q.delete();
                clear_bits();
                run = 0;
            end else begin
                run = stb_o ? run + 1 : 0;
                if (run > run_max) run_max = run;
                if (stb_o && !ack_i) chk("ack_o_halt", 64'(ack_o), 64'd0);
                if (stb_o && ack_i) begin
                    sym_cnt++;
                    chk("we_o", 64'(we_o), 64'd1);
                    chk("sym_expected", 64'(exp16_q.size() != 0), 64'd1);
                    if (exp16_q.size() != 0) begin
                        e16 = exp16_q.pop_front();
                        e20 = exp20_q.pop_front();
                        chk("sym16", 64'(dat_o), 64'(e16));
                        chk("sym20", 64'(dat_o20), 64'(e20));
                    end
                    if (const16_q.size() != 0) begin
                        e16 = const16_q.pop_front();
                        chk("sym16_const", 64'(dat_o), 64'(e16));
                    end
                    if (const20_q.size() != 0) begin
                        e20 = const20_q.pop_front();
                        chk("sym20_const", 64'(dat_o20), 64'(e20));
                    end
                end
                if (ack_o) begin
                    mb[mn] = int'(dat_i[0]);
                    mn++;
                    if (fmode != 0) begin
                        mb[mn] = int'(dat_i[1]);
                        mn++;
                    end
                    if (mn == nbits(fmode)) push_sym();
                end
                if (!cyc_i && mn > 0) push_sym();
            end
        end
    end

    initial begin
        ack_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       ack_i = 1'b1;
                1:       ack_i = 1'($urandom_range(0, 1));
                default: ack_i = 1'b0;
            endcase
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input int md);
        fmode  = md;
        mode_i = 2'(md);
        cyc_i  = 1'b1;
    endtask

    task automatic put_beat(input logic [1:0] d, input int gap, output int waited);
        int t;
        t = 0;
        dat_i = d;
        stb_i = 1'b1;
        we_i  = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (!ack_o && t < 200);
        if (!ack_o) chk("beat_timeout", 64'(ack_o), 64'd1);
        @(posedge clk);
        #1;
        waited = t;
        for (int i = 0; i < gap; i++) begin
            stb_i = 1'($urandom_range(0, 1));
            we_i  = 1'b0;
            dat_i = 2'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic end_frame();
        int t;
        t = 0;
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        do begin
            @(negedge clk);
            t++;
        end while (cyc_o && t < 500);
        chk("cyc_o_drop", 64'(cyc_o), 64'd0);
        chk("queue_empty", 64'(exp16_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    int w, s0, t;

    initial begin
        rst = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
        mode_i = 2'd0; dat_i = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stb", 64'(stb_o), 64'd0);
        chk("rst_cyc", 64'(cyc_o), 64'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_ack", 64'(ack_o), 64'd0);
        chk("rst_we", 64'(we_o), 64'd0);
        chk("rst_stb20", 64'(stb_o20), 64'd0);
        chk("rst_cyc20", 64'(cyc_o20), 64'd0);
        chk("rst_dat20", 64'(dat_o20), 64'd0);
        chk("rst_ack20", 64'(ack_o20), 64'd0);
        chk("rst_we20", 64'(we_o20), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // QPSK, back-to-back with ACK_I held high
        ack_mode = 0; run_max = 0; s0 = sym_cnt;
        const16_q.push_back(pk16(-11585, -11585));
        const16_q.push_back(pk16(-11585, 11585));
        const16_q.push_back(pk16(11585, -11585));
        const16_q.push_back(pk16(11585, 11585));
        start_frame(1);
        put_beat(2'b00, 0, w);
        chk("qpsk_cyc_o", 64'(cyc_o), 64'd1);
        put_beat(2'b01, 0, w); chk("qpsk_ack2", 64'(w), 64'd1);
        put_beat(2'b10, 0, w); chk("qpsk_ack3", 64'(w), 64'd1);
        put_beat(2'b11, 0, w); chk("qpsk_ack4", 64'(w), 64'd1);
        end_frame();
        chk("qpsk_stb_run", 64'(run_max), 64'd4);
        chk("qpsk_syms", 64'(sym_cnt - s0), 64'd4);

        // 64QAM single symbol
        run_max = 0; s0 = sym_cnt;
        const16_q.push_back(pk16(2528, -17697));
        start_frame(3);
        put_beat(2'b00, 0, w);
        put_beat(2'b10, 0, w); chk("q64_ack2", 64'(w), 64'd1);
        put_beat(2'b01, 0, w); chk("q64_ack3", 64'(w), 64'd1);
        end_frame();
        chk("q64_stb_run", 64'(run_max), 64'd1);
        chk("q64_syms", 64'(sym_cnt - s0), 64'd1);

        // 16QAM, 20 symbols under random backpressure
        ack_mode = 1; s0 = sym_cnt;
        start_frame(2);
        for (int i = 0; i < 40; i++) put_beat(2'($urandom), $urandom_range(0, 2), w);
        end_frame();
        chk("q16_syms", 64'(sym_cnt - s0), 64'd20);

        // 64QAM with a partial trailing symbol
        s0 = sym_cnt;
        const16_q.push_back(pk16(2528, -17697));
        const16_q.push_back(pk16(-17697, 17697));
        start_frame(3);
        put_beat(2'b00, 0, w);
        put_beat(2'b10, 0, w);
        put_beat(2'b01, 0, w);
        put_beat(2'b01, 0, w);
        end_frame();
        chk("flush_syms", 64'(sym_cnt - s0), 64'd2);

        // BPSK, MODE_I wiggled mid-frame
        ack_mode = 0; s0 = sym_cnt;
        const16_q.push_back(pk16(0, -16384));
        const16_q.push_back(pk16(0, 16384));
        start_frame(0);
        put_beat(2'b10, 0, w);
        mode_i = 2'd3;
        put_beat(2'b01, 0, w);
        mode_i = 2'd2;
        end_frame();
        chk("bpsk_syms", 64'(sym_cnt - s0), 64'd2);

        // DW=20 16QAM +3/+3
        const16_q.push_back(pk16(15543, 15543));
        const20_q.push_back({20'd248688, 20'd248688});
        start_frame(2);
        put_beat(2'b01, 0, w);
        put_beat(2'b01, 0, w);
        end_frame();

        // reset while a symbol is held
        ack_mode = 2;
        start_frame(2);
        put_beat(2'b01, 0, w);
        put_beat(2'b10, 0, w);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!stb_o && t < 20);
        chk("stb_before_rst", 64'(stb_o), 64'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_stb", 64'(stb_o), 64'd0);
        chk("mid_rst_cyc", 64'(cyc_o), 64'd0);
        chk("mid_rst_ack", 64'(ack_o), 64'd0);
        chk("mid_rst_stb20", 64'(stb_o20), 64'd0);
        chk("mid_rst_cyc20", 64'(cyc_o20), 64'd0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; ack_mode = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // random frames
        for (int f = 0; f < 10; f++) begin
            ack_mode = $urandom_range(0, 1);
            start_frame($urandom_range(0, 3));
            for (int b = 0; b < int'($urandom_range(1, 10)); b++)
                put_beat(2'($urandom), $urandom_range(0, 2), w);
            end_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
- Parametrised multi-mode 802.11a constellation mapper: BPSK, QPSK, 16-QAM and 64-QAM.
- Sits between the interleaver and the pilot-insertion/IFFT stage. Consumes a 2-bit-per-beat Wishbone-style stream and emits one complex symbol {Im,Re} per constellation point.
- Gathers 1, 2, 4 or 6 coded bits per symbol depending on a per-frame mode.
- Pads and flushes a partial symbol at frame end.

Parameters:
- DW, 16, width of each I/Q component, two's complement. Legal range 16..24.

Ports:
- CLK_I  in  1  clock
- RST_I  in  1  reset
- MODE_I  in  2  0=BPSK 1=QPSK 2=16QAM 3=64QAM; sampled at frame start
- DAT_I  in  2  coded bits; DAT_I[0] is the earlier bit
- CYC_I  in  1  frame envelope from upstream
- STB_I  in  1  input strobe
- WE_I  in  1  input write
- ACK_O  out  1  input accept
- DAT_O  out  2*DW  {Im[DW-1:0], Re[DW-1:0]}
- CYC_O  out  1  frame envelope to downstream
- STB_O  out  1  output valid
- WE_O  out  1  equals STB_O
- ACK_I  in  1  downstream accept

Behaviour:
- Clock and reset: one clock, CLK_I. RST_I is synchronous and active-high.
- Reset values: state=IDLE, STB_O=0, CYC_O=0, DAT_O=0, ACK_O=0 (combinational, driven low via state), gather count=0, bit register=0.
- Handshake:
  - out_halt = STB_O & ~ACK_I.
  - ena = CYC_I & STB_I & WE_I.
  - ACK_O = ena & ~out_halt & (state==RUN).
  - A beat transfers when ACK_O=1.
  - Once asserted, STB_O/DAT_O hold until ACK_I.
- Bits per beat: BPSK uses DAT_I[0] only (DAT_I[1] ignored), giving 1 symbol per beat. QPSK takes 1 beat per symbol, 16QAM 2 beats, 64QAM 3 beats.
- Bit order: b0 is the first bit received.
- Gather counter: 0..(beats-1).
  - Non-final beats shift into the bit register.
  - On the final beat, the register plus DAT_I are mapped and registered into DAT_O with STB_O=1 on the next edge (latency 1 cycle).
  - Counter wraps to 0.
- Mapping (0 bit = negative side), Re from the I bits:
  - BPSK: b0 gives Re = ±L1; Im = 0.
  - QPSK: b0 gives I, b1 gives Q, each ±L1.
  - 16QAM: I from b0b1, Q from b2b3. 00→-3, 01→-1, 11→+1, 10→+3.
  - 64QAM: I from b0b1b2, Q from b3b4b5. 000→-7, 001→-5, 011→-3, 010→-1, 110→+1, 111→+3, 101→+5, 100→+7.
- Levels: DW=16 constants (Q2.14), shifted left by DW-16 for wider DW.
  - BPSK ±1 = 16384.
  - QPSK ±1 = 11585.
  - 16QAM ±1 = 5181, ±3 = 15543.
  - 64QAM ±1 = 2528, ±3 = 7584, ±5 = 12641, ±7 = 17697.
  - Negative values are exact two's complement negation.
- FSM:
  - IDLE: on CYC_I=1, latch MODE_I, set CYC_O=1, go to RUN.
  - RUN: accept beats. When CYC_I=0: go to FLUSH if count≠0, otherwise to DRAIN.
  - FLUSH: once ~out_halt, emit the partial symbol with missing bits = 0, clear count, go to DRAIN. No input is accepted in FLUSH.
  - DRAIN: when STB_O=0, or STB_O&ACK_I, clear CYC_O and go to IDLE.
- STB_O drops the cycle after ACK_I if no new symbol is being registered. Back-to-back symbols with ACK_I held high give 1 symbol/cycle in QPSK/BPSK.
- MODE_I changes during RUN are ignored.
- CYC_I reasserting while in FLUSH or DRAIN is ignored until IDLE. The upstream must hold CYC_I low ≥1 cycle between frames.
- RST_I mid-frame: all state cleared on the next edge; any pending symbol is discarded; STB_O and CYC_O go to 0.

Test Plan:
- Reset, DW=16, MODE=QPSK, beats 00,01,10,11 with ACK_I=1 → DAT_O = {Im,Re}:
  - 00: {-11585,-11585}
  - 01: {-11585,+11585}
  - 10: {+11585,-11585}
  - 11: {+11585,+11585}
  - Each appears 1 cycle after its accept; STB_O high for 4 consecutive cycles.
- MODE=64QAM, beats DAT_I=2'b00, 2'b10, 2'b01 (b0..b5=0,0,0,1,1,0) → a single symbol Re=-17697, Im=+2528. ACK_O is high on all three beats; STB_O pulses once.
- MODE=16QAM, ACK_I=0 while STB_O=1 → ACK_O=0, DAT_O stable. After ACK_I rises, the queued input is accepted the next cycle; no symbol is lost or duplicated across 20 random symbols checked against a golden model.
- MODE=64QAM, CYC_I drops after 4 beats:
  - First symbol emitted normally.
  - FLUSH emits b0=1,b1=0, rest 0 (bits 1,0,0,0,0,0) → Re=+17697, Im=-17697.
  - CYC_O falls after that symbol is acked.
- MODE=BPSK with DAT_I=2'b10 then 2'b01 → Re=-16384 then +16384, Im=0. MODE_I toggled mid-frame has no effect.
- DW=20, 16QAM symbol bits 1,0,1,0 → Re=Im=248688 (15543<<4). Also assert RST_I mid-frame with STB_O=1 → STB_O=0, CYC_O=0, state IDLE on the next edge.
